// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with per-key press/release debouncing.
// Rows rotate on a divided scan tick; a single-key column hit freezes the row while it debounces.
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEB_N    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    typedef enum logic [1:0] {StScan, StDebounce, StHold, StRelease} state_e;

    state_e      state_q, state_d;
    logic [3:0]  col_meta_q, col_s_q;
    logic [15:0] div_q;
    logic        tick;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [3:0]  cap_q, cap_d;
    logic [3:0]  deb_q, deb_d;
    logic [3:0]  deb_inc;
    logic        deb_done;
    logic [3:0]  col_n;
    logic        one_low;
    logic [1:0]  cap_idx;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        down_q, down_d;

    assign tick     = (div_q == 16'(SCAN_DIV - 1));
    assign col_n    = ~col_s_q;
    assign one_low  = (col_n != 4'd0) && ((col_n & (col_n - 4'd1)) == 4'd0);
    // Saturate rather than wrap so a long run of agreeing ticks can never alias to zero.
    assign deb_inc  = (deb_q == 4'hF) ? deb_q : deb_q + 4'd1;
    assign deb_done = (32'(deb_inc) >= DEB_N);

    assign row       = ~(4'b0001 << row_idx_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

    always_comb begin
        case (cap_q)
            4'b1110: cap_idx = 2'd0;
            4'b1101: cap_idx = 2'd1;
            4'b1011: cap_idx = 2'd2;
            4'b0111: cap_idx = 2'd3;
            default: cap_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        cap_d     = cap_q;
        deb_d     = deb_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        down_d    = down_q;
        if (tick) begin
            case (state_q)
                StScan: begin
                    if (one_low) begin
                        cap_d   = col_s_q;
                        deb_d   = 4'd0;
                        state_d = StDebounce;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                StDebounce: begin
                    if (col_s_q == cap_q) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            state_d = StHold;
                            code_d  = {row_idx_q, cap_idx};
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                        end
                    end else begin
                        state_d   = StScan;
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                StHold: begin
                    if (col_s_q == 4'hF) begin
                        deb_d   = 4'd0;
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (col_s_q == 4'hF) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            down_d    = 1'b0;
                            state_d   = StScan;
                            row_idx_d = row_idx_q + 2'd1;
                        end
                    end else begin
                        state_d = StHold;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StScan;
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
            div_q      <= 16'd0;
            row_idx_q  <= 2'd0;
            cap_q      <= 4'hF;
            deb_q      <= 4'd0;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_meta_q <= col;
            col_s_q    <= col_meta_q;
            div_q      <= tick ? 16'd0 : div_q + 16'd1;
            row_idx_q  <= row_idx_d;
            cap_q      <= cap_d;
            deb_q      <= deb_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            down_q     <= down_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV = 4, DEB_N = 3 and a behavioural keypad model.
// Cycle numbers count rising edges since the last reset release; samples are taken 1 time unit after.
module tb_keypad_scan;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB_N    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_down;

    logic       key_on = 1'b0;
    logic       ghost = 1'b0;
    logic [1:0] key_r = 2'd2;
    logic [1:0] key_c = 2'd1;

    int   cyc;
    int   vcnt = 0;
    int   dbl = 0;
    logic prev_v = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    int   base;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_N(DEB_N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low only while its row is driven.
    always_comb begin
        col = 4'hF;
        if (ghost) begin
            col = (row == 4'b1110) ? 4'b1001 : 4'hF;
        end else if (key_on && (row == ~(4'b0001 << key_r))) begin
            col = ~(4'b0001 << key_c);
        end
    end

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            vcnt <= vcnt + 1;
            if (prev_v) dbl <= dbl + 1;
        end
        prev_v <= rst_n && key_valid;
    end

    typedef struct {
        int         cyc;
        logic       key_on;
        logic [3:0] row;
        logic       valid;
        logic       down;
        logic [3:0] code;
        int         vcnt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // key (2,1) held from reset release, released after cycle 25
        tbl[0]  = '{1,  1'b1, 4'b1110, 1'b0, 1'b0, 4'd0, 0};
        tbl[1]  = '{3,  1'b1, 4'b1110, 1'b0, 1'b0, 4'd0, 0};
        tbl[2]  = '{4,  1'b1, 4'b1101, 1'b0, 1'b0, 4'd0, 0};
        tbl[3]  = '{8,  1'b1, 4'b1011, 1'b0, 1'b0, 4'd0, 0};
        tbl[4]  = '{12, 1'b1, 4'b1011, 1'b0, 1'b0, 4'd0, 0};
        tbl[5]  = '{16, 1'b1, 4'b1011, 1'b0, 1'b0, 4'd0, 0};
        tbl[6]  = '{23, 1'b1, 4'b1011, 1'b0, 1'b0, 4'd0, 0};
        tbl[7]  = '{24, 1'b1, 4'b1011, 1'b1, 1'b1, 4'd9, 0};
        tbl[8]  = '{25, 1'b0, 4'b1011, 1'b0, 1'b1, 4'd9, 1};
        tbl[9]  = '{39, 1'b0, 4'b1011, 1'b0, 1'b1, 4'd9, 1};
        tbl[10] = '{40, 1'b0, 4'b0111, 1'b0, 1'b0, 4'd9, 1};
        tbl[11] = '{44, 1'b0, 4'b1110, 1'b0, 1'b0, 4'd9, 1};

        // Reset values with the clock running
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row", 32'(row), 32'(4'b1110));
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_down", 32'(key_down), 32'd0);
        key_on = 1'b1; key_r = 2'd2; key_c = 2'd1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wait_cyc(tbl[i].cyc);
            chk($sformatf("vec%0d_out", i), {22'd0, row, key_valid, key_down, key_code},
                {22'd0, tbl[i].row, tbl[i].valid, tbl[i].down, tbl[i].code});
            chk($sformatf("vec%0d_pulses", i), 32'(vcnt), 32'(tbl[i].vcnt));
            key_on = tbl[i].key_on;
        end

        // Bounce: match on two debounce ticks only, then release
        base = vcnt;
        key_on = 1'b1; key_r = 2'd2; key_c = 2'd1;
        apply_reset();
        wait_cyc(20);
        chk("bounce_frozen", {28'd0, row}, {28'd0, 4'b1011});
        wait_cyc(21);
        key_on = 1'b0;
        wait_cyc(24);
        chk("bounce_rotate", {26'd0, row, key_down, key_valid}, {26'd0, 4'b0111, 1'b0, 1'b0});
        wait_cyc(28);
        chk("bounce_row", 32'(row), 32'(4'b1110));
        chk("bounce_pulses", 32'(vcnt), 32'(base));

        // Ghost: two low columns never capture
        base = vcnt;
        ghost = 1'b1;
        apply_reset();
        wait_cyc(4);
        chk("ghost_row4", 32'(row), 32'(4'b1101));
        wait_cyc(16);
        chk("ghost_row16", 32'(row), 32'(4'b1110));
        wait_cyc(20);
        chk("ghost_row20", 32'(row), 32'(4'b1101));
        chk("ghost_down", 32'(key_down), 32'd0);
        chk("ghost_pulses", 32'(vcnt), 32'(base));
        ghost = 1'b0;

        // Release glitch: key returns for one tick during release debounce
        key_on = 1'b1; key_r = 2'd2; key_c = 2'd1;
        apply_reset();
        wait_cyc(25);
        chk("glitch_accept", {27'd0, key_down, key_code}, {27'd0, 1'b1, 4'd9});
        base = vcnt;
        key_on = 1'b0;
        wait_cyc(33);
        chk("glitch_rel_down", 32'(key_down), 32'd1);
        key_on = 1'b1;
        wait_cyc(35);
        key_on = 1'b0;
        wait_cyc(51);
        chk("glitch_still_down", {27'd0, row, key_down}, {27'd0, 4'b1011, 1'b1});
        wait_cyc(52);
        chk("glitch_released", {27'd0, row, key_down}, {27'd0, 4'b0111, 1'b0});
        chk("glitch_pulses", 32'(vcnt), 32'(base));

        // Mid-operation reset while holding key 15
        key_on = 1'b1; key_r = 2'd3; key_c = 2'd3;
        apply_reset();
        wait_cyc(29);
        chk("k15_accept", {27'd0, key_down, key_code}, {27'd0, 1'b1, 4'd15});
        base = vcnt;
        rst_n = 1'b0;
        #1;
        chk("k15_async_rst", {22'd0, row, key_valid, key_down, key_code},
            {22'd0, 4'b1110, 1'b0, 1'b0, 4'd0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(29);
        chk("k15_reaccept", {23'd0, row, key_down, key_code}, {23'd0, 4'b0111, 1'b1, 4'd15});
        wait_cyc(40);
        chk("k15_pulses", 32'(vcnt), 32'(base + 1));
        chk("no_double_pulse", 32'(dbl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per scan tick (legal range 4..65535).
REQ-002 The module SHALL have parameter DEB_N, default 4, meaning consecutive agreeing ticks needed to accept a press or release (legal range 1..15).
REQ-003 The module SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port row, output, 4, active-low row drive to a 4x4 matrix keypad.
REQ-006 The module SHALL have port col, input, 4, active-low column sense (pulled up; 1111 = no key), asynchronous to clk.
REQ-007 The module SHALL have port key_code, output, 4, code of the last accepted key.
REQ-008 The module SHALL have port key_valid, output, 1, single-cycle strobe on acceptance of a new key.
REQ-009 The module SHALL have port key_down, output, 1, level that is high from acceptance of a key until its accepted release.

Function
REQ-010 col SHALL pass through a two-flop synchronizer; every decision below uses only the synchronized value colS.
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap to 0, asserting an internal tick in the cycle it equals SCAN_DIV-1.
REQ-012 Exactly one row bit SHALL be low at all times; rotation order is 1110 -> 1101 -> 1011 -> 0111 -> 1110, with row index r = 0..3 respectively.
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE, HOLD and RELEASE; all transitions occur only on tick.
REQ-014 In SCAN, if colS = 1111 or colS has more than one low bit, row SHALL rotate on the tick and the FSM SHALL stay in SCAN.
REQ-015 In SCAN, if colS has exactly one low bit, the FSM SHALL capture r and colS, freeze row, clear the debounce count and enter DEBOUNCE.
REQ-016 In DEBOUNCE, when colS equals the captured value, the debounce count SHALL increment on each tick.
REQ-017 In DEBOUNCE, when the count reaches DEB_N, the FSM SHALL enter HOLD and, in the same cycle, load key_code = r*4 + c (c = index of the low column bit, 0..3), pulse key_valid for one clk cycle and set key_down = 1.
REQ-018 In DEBOUNCE, if colS differs from the captured value on a tick, the FSM SHALL return to SCAN, rotate row, and produce no key_valid pulse.
REQ-019 In HOLD, row SHALL stay frozen; a tick with colS = 1111 SHALL clear the count and enter RELEASE; any other colS SHALL keep the FSM in HOLD; no further key_valid pulse SHALL occur.
REQ-020 In RELEASE, each tick with colS = 1111 SHALL increment the count.
REQ-021 In RELEASE, when the count reaches DEB_N, the FSM SHALL clear key_down, return to SCAN and rotate row.
REQ-022 In RELEASE, a tick with colS != 1111 SHALL return the FSM to HOLD with key_down still 1.
REQ-023 key_code SHALL hold its value until the next acceptance; key_valid SHALL never be high for two consecutive cycles.
REQ-024 With DEB_N = 1, acceptance SHALL occur on the first DEBOUNCE tick whose colS matches.
REQ-025 Debounce counters SHALL saturate and SHALL never wrap.

Reset
REQ-026 While rst_n = 0, all outputs SHALL take their reset values immediately, independent of clk: row = 1110, key_code = 0000, key_valid = 0, key_down = 0.
REQ-027 While rst_n = 0, the FSM SHALL be held in SCAN and the tick counter, debounce count and synchronizer flops SHALL be held at 0 (synchronizer at 1111).
REQ-028 Reset asserted in any state, including mid-DEBOUNCE or HOLD, SHALL abort the operation with no key_valid pulse.
REQ-029 After rst_n deasserts, scanning SHALL restart from row 1110.

Verification (SCAN_DIV = 4, DEB_N = 3)
REQ-030 Reset check: drive rst_n = 0 with clk running -> row = 1110, key_code = 0, key_valid = 0, key_down = 0; after release, row steps 1110 -> 1101 every 4 clks.
REQ-031 Clean press: model key at row 2, col 1 (col = 1101 only while row = 1011), held -> row freezes at 1011, key_code = 9, exactly one key_valid pulse 3 ticks after capture, key_down = 1; on release, key_down = 0 after 3 quiet ticks and rotation resumes at 0111.
REQ-032 Bounce: same key held for only 2 ticks after capture, then released -> no key_valid, key_down stays 0, scanning resumes.
REQ-033 Ghost: col = 1001 while row = 1110 -> no capture, row keeps rotating, no key_valid.
REQ-034 Release glitch: in RELEASE, col returns to 1101 for 1 tick -> FSM back to HOLD, key_down stays 1, no second key_valid.
REQ-035 Mid-operation reset: rst_n pulsed low while in HOLD on key 15 (row 0111, col 0111) -> key_down = 0, key_code = 0, row = 1110 immediately; key re-accepted after restart with exactly one pulse.
